// File: rtl/hdmi_timing_pkg.sv
// Shared widths, reset wrap values and count types for the HDMI raster timing counters.
package hdmi_timing_pkg;

  localparam int H_WIDTH_DEF   = 11;
  localparam int V_WIDTH_DEF   = 10;
  localparam int H_MAX_RST_DEF = 1250;
  localparam int V_MAX_RST_DEF = 749;

  typedef logic [H_WIDTH_DEF-1:0] h_count_t;
  typedef logic [V_WIDTH_DEF-1:0] v_count_t;

endpackage

// File: rtl/hv_timing_counter_wrap.sv
// wrap_counter: generic modulo counter with a run-time wrap value, synchronous
// parallel load and a registered one-cycle terminal-count pulse.
// The wrap compare uses >=, so a count loaded above max still wraps on the next
// enabled cycle instead of running to 2^WIDTH.
module wrap_counter
  import hdmi_timing_pkg::*;
#(
  parameter int WIDTH = H_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             MR,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] dn,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  assign at_max = (count_q >= max);

  // Next count and pulse: load beats enable; tc is only ever high for one cycle.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = dn;
    end else if (enable) begin
      if (at_max) begin
        count_d = '0;
        tc_d    = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  // Count and pulse registers, cleared asynchronously by master reset.
  always_ff @(posedge clock or posedge MR) begin
    if (MR) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: rtl/hv_timing_counter.sv
// hv_timing_counter: cascaded horizontal/vertical raster counter with shadowed,
// run-time programmable wrap values. The requested h_max/v_max are copied into
// the shadows only on the frame wrap, so register writes never tear a frame.
// Optional feature macro: HV_SYNC_OUT_EN adds registered h_sync/v_sync windows.
module hv_timing_counter
  import hdmi_timing_pkg::*;
#(
  parameter int H_WIDTH   = H_WIDTH_DEF,
  parameter int V_WIDTH   = V_WIDTH_DEF,
  parameter int H_MAX_RST = H_MAX_RST_DEF,
  parameter int V_MAX_RST = V_MAX_RST_DEF
) (
  input  logic               clock,
  input  logic               MR,
  input  logic               CEP,
  input  logic               PE_n,
  input  logic [H_WIDTH-1:0] h_dn,
  input  logic [V_WIDTH-1:0] v_dn,
  input  logic [H_WIDTH-1:0] h_max,
  input  logic [V_WIDTH-1:0] v_max,
`ifdef HV_SYNC_OUT_EN
  input  logic [H_WIDTH-1:0] h_sync_start,
  input  logic [H_WIDTH-1:0] h_sync_end,
  input  logic [V_WIDTH-1:0] v_sync_start,
  input  logic [V_WIDTH-1:0] v_sync_end,
  output logic               h_sync,
  output logic               v_sync,
`endif
  output logic [H_WIDTH-1:0] h_count,
  output logic [V_WIDTH-1:0] v_count,
  output logic               h_tc,
  output logic               v_tc,
  output logic               frame_start
);

  logic               load;
  logic               h_at_max;
  logic               v_at_max;
  logic               v_enable;
  logic               frame_wrap;
  logic [H_WIDTH-1:0] h_max_sh_q, h_max_sh_d;
  logic [V_WIDTH-1:0] v_max_sh_q, v_max_sh_d;

  assign load       = ~PE_n;
  // Vertical advances only on a horizontal wrap; a frame wraps when both wrap together.
  assign v_enable   = CEP & h_at_max;
  assign frame_wrap = PE_n & CEP & h_at_max & v_at_max;

  wrap_counter #(.WIDTH(H_WIDTH)) u_h_cnt (
    .clock  (clock),
    .MR     (MR),
    .load   (load),
    .enable (CEP),
    .dn     (h_dn),
    .max    (h_max_sh_q),
    .count  (h_count),
    .at_max (h_at_max),
    .tc     (h_tc)
  );

  wrap_counter #(.WIDTH(V_WIDTH)) u_v_cnt (
    .clock  (clock),
    .MR     (MR),
    .load   (load),
    .enable (v_enable),
    .dn     (v_dn),
    .max    (v_max_sh_q),
    .count  (v_count),
    .at_max (v_at_max),
    .tc     (v_tc)
  );

  // Shadow wrap values follow the requested values only at the frame wrap.
  always_comb begin
    h_max_sh_d = h_max_sh_q;
    v_max_sh_d = v_max_sh_q;
    if (frame_wrap) begin
      h_max_sh_d = h_max;
      v_max_sh_d = v_max;
    end
  end

  // Shadow registers start from the default raster on master reset.
  always_ff @(posedge clock or posedge MR) begin
    if (MR) begin
      h_max_sh_q <= H_WIDTH'(H_MAX_RST);
      v_max_sh_q <= V_WIDTH'(V_MAX_RST);
    end else begin
      h_max_sh_q <= h_max_sh_d;
      v_max_sh_q <= v_max_sh_d;
    end
  end

  assign frame_start = (h_count == '0) && (v_count == '0);

`ifdef HV_SYNC_OUT_EN
  localparam logic [H_WIDTH-1:0] H_ONE = H_WIDTH'(1);
  localparam logic [V_WIDTH-1:0] V_ONE = V_WIDTH'(1);

  logic               h_sync_q, h_sync_d;
  logic               v_sync_q, v_sync_d;
  logic [H_WIDTH-1:0] h_next;
  logic [V_WIDTH-1:0] v_next;

  // Sync windows are decoded on the count about to be registered, so they line up with it.
  always_comb begin
    h_next   = h_at_max ? '0 : (h_count + H_ONE);
    v_next   = v_enable ? (v_at_max ? '0 : (v_count + V_ONE)) : v_count;
    h_sync_d = h_sync_q;
    v_sync_d = v_sync_q;
    if (load) begin
      h_sync_d = 1'b0;
      v_sync_d = 1'b0;
    end else if (CEP) begin
      h_sync_d = (h_next >= h_sync_start) && (h_next <= h_sync_end);
      v_sync_d = (v_next >= v_sync_start) && (v_next <= v_sync_end);
    end
  end

  // Sync output registers, cleared by master reset.
  always_ff @(posedge clock or posedge MR) begin
    if (MR) begin
      h_sync_q <= 1'b0;
      v_sync_q <= 1'b0;
    end else begin
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
    end
  end

  assign h_sync = h_sync_q;
  assign v_sync = v_sync_q;
`endif

endmodule

// File: tb/tb_hv_timing_counter.sv
// Scoreboard bench for hv_timing_counter: the driver pushes the hand-derived
// expected outputs for each vector; a monitor pops and compares after each edge
// (and after an asynchronous reset assertion).
module tb_hv_timing_counter;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        htc;
    logic        vtc;
    logic        fs;
    string       nm;
  } exp_t;

  logic        clock = 1'b0;
  logic        MR;
  logic        CEP;
  logic        PE_n;
  logic [10:0] h_dn;
  logic [9:0]  v_dn;
  logic [10:0] h_max;
  logic [9:0]  v_max;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic        h_tc;
  logic        v_tc;
  logic        frame_start;

  exp_t exp_q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;

  hv_timing_counter dut (
    .clock       (clock),
    .MR          (MR),
    .CEP         (CEP),
    .PE_n        (PE_n),
    .h_dn        (h_dn),
    .v_dn        (v_dn),
    .h_max       (h_max),
    .v_max       (v_max),
    .h_count     (h_count),
    .v_count     (v_count),
    .h_tc        (h_tc),
    .v_tc        (v_tc),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  task automatic push_exp(input int eh, input int ev, input logic eht, input logic evt,
                          input string nm);
    exp_t x;
    x.h   = 11'(eh);
    x.v   = 10'(ev);
    x.htc = eht;
    x.vtc = evt;
    x.fs  = (eh == 0) && (ev == 0);
    x.nm  = nm;
    exp_q.push_back(x);
  endtask

  // Drive one vector on the falling edge; its result is checked after the next rising edge.
  task automatic step(input logic mr, input logic cep, input logic pe_n,
                      input int hdn, input int vdn,
                      input int eh, input int ev, input logic eht, input logic evt,
                      input string nm);
    @(negedge clock);
    MR   = mr;
    CEP  = cep;
    PE_n = pe_n;
    h_dn = 11'(hdn);
    v_dn = 10'(vdn);
    push_exp(eh, ev, eht, evt, nm);
  endtask

  // Monitor: compare outputs against the oldest pending expectation.
  initial begin
    forever begin
      @(posedge clock or posedge MR);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (h_count !== e.h || v_count !== e.v || h_tc !== e.htc ||
            v_tc !== e.vtc || frame_start !== e.fs) begin
          n_bad++;
          $display("FAIL %s: got h=%0d v=%0d h_tc=%b v_tc=%b fs=%b, want h=%0d v=%0d h_tc=%b v_tc=%b fs=%b",
                   e.nm, h_count, v_count, h_tc, v_tc, frame_start,
                   e.h, e.v, e.htc, e.vtc, e.fs);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  int eh7[16] = '{3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 5, 6, 7, 0};
  int ev7[16] = '{1, 1, 2, 2, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    MR = 1'b1; CEP = 1'b0; PE_n = 1'b1;
    h_dn = '0; v_dn = '0; h_max = 11'd4; v_max = 10'd2;

    // Reset hold and clean release
    step(1, 1, 1, 0, 0,  0, 0, 0, 0, "reset_hold");
    step(0, 0, 1, 0, 0,  0, 0, 0, 0, "release_idle");
    step(0, 1, 1, 0, 0,  1, 0, 0, 0, "first_count");

    // Reset shadows are 1250/749; requested 4/2 ignored mid-frame
    step(0, 1, 0, 1249, 748,  1249, 748, 0, 0, "load_1249_748");
    step(0, 1, 1, 0, 0,  1250, 748, 0, 0, "h_at_rst_max");
    step(0, 1, 1, 0, 0,  0, 749, 1, 0, "h_wrap_rst_max");
    step(0, 1, 0, 1250, 749,  1250, 749, 0, 0, "load_1250_749");
    step(0, 1, 1, 0, 0,  0, 0, 1, 1, "frame_wrap_latch");

    // 5x3 raster with CEP held high
    for (int i = 1; i <= 16; i++)
      step(0, 1, 1, 0, 0, i % 5, (i / 5) % 3, (i % 5) == 0, (i % 15) == 0, "raster_5x3");

    // Load beats CEP, then counting resumes
    step(0, 1, 0, 3, 1,  3, 1, 0, 0, "load_over_cep");
    step(0, 1, 1, 0, 0,  4, 1, 0, 0, "post_load_4");
    step(0, 1, 1, 0, 0,  0, 2, 1, 0, "post_load_wrap");

    // Change h_max mid-frame: takes effect only after the frame wrap
    step(0, 1, 0, 2, 1,  2, 1, 0, 0, "load_2_1");
    h_max = 11'd7;
    for (int i = 0; i < 16; i++)
      step(0, 1, 1, 0, 0, eh7[i], ev7[i], eh7[i] == 0, i == 7, "shadow_change");

    // Out-of-range loads wrap on the next enabled cycle
    step(0, 1, 0, 10, 0,  10, 0, 0, 0, "load_h_oor");
    step(0, 1, 1, 0, 0,  0, 1, 1, 0, "h_oor_wrap");
    h_max = 11'd4;
    step(0, 1, 0, 7, 5,  7, 5, 0, 0, "load_v_oor");
    step(0, 1, 1, 0, 0,  0, 0, 1, 1, "v_oor_wrap");

    // CEP toggled around a wrap
    step(0, 1, 0, 3, 0,  3, 0, 0, 0, "tog_load_3");
    step(0, 1, 1, 0, 0,  4, 0, 0, 0, "tog_4");
    step(0, 1, 1, 0, 0,  0, 1, 1, 0, "tog_wrap");
    step(0, 0, 1, 0, 0,  0, 1, 0, 0, "tog_hold");
    step(0, 1, 1, 0, 0,  1, 1, 0, 0, "tog_resume");
    step(0, 0, 1, 0, 0,  1, 1, 0, 0, "hold_mid");

    // Asynchronous reset between edges at h=37, v=5
    step(0, 1, 0, 37, 5,  37, 5, 0, 0, "load_37_5");
    @(posedge clock);
    #3;
    push_exp(0, 0, 0, 0, "async_reset");
    MR = 1'b1;
    step(1, 1, 1, 0, 0,  0, 0, 0, 0, "reset_hold2");
    step(0, 1, 1, 0, 0,  1, 0, 0, 0, "release_count");
    step(0, 1, 1, 0, 0,  2, 0, 0, 0, "release_count2");

    // Zero wrap values: stuck at 0 with both pulses every enabled cycle
    h_max = 11'd0;
    v_max = 10'd0;
    step(0, 1, 0, 1250, 749,  1250, 749, 0, 0, "load_for_zero");
    step(0, 1, 1, 0, 0,  0, 0, 1, 1, "zero_latch");
    step(0, 1, 1, 0, 0,  0, 0, 1, 1, "zero_stuck");
    step(0, 0, 1, 0, 0,  0, 0, 0, 0, "zero_hold");
    step(0, 1, 1, 0, 0,  0, 0, 1, 1, "zero_stuck2");

    @(posedge clock);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
